// File: rtl/present_pkg.sv
// present_pkg: register map, widths and FSM state type shared by the PRESENT bus master
package present_pkg;

    localparam int KEY_W = 80;
    localparam int BLK_W = 64;

    localparam logic [3:0] ADDR_LOAD = 4'h0;
    localparam logic [3:0] ADDR_KEY0 = 4'h1;
    localparam logic [3:0] ADDR_KEY1 = 4'h2;
    localparam logic [3:0] ADDR_KEY2 = 4'h3;
    localparam logic [3:0] ADDR_DAT0 = 4'h4;
    localparam logic [3:0] ADDR_DAT1 = 4'h5;
    localparam logic [3:0] ADDR_RES0 = 4'h6;
    localparam logic [3:0] ADDR_RES1 = 4'h7;
    localparam logic [3:0] ADDR_CTRL = 4'h8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CTRL,
        S_WR_K0,
        S_WR_K1,
        S_WR_K2,
        S_WR_D0,
        S_WR_D1,
        S_WR_LOAD,
        S_LD_CLR,
        S_WAIT,
        S_RD_HI,
        S_RD_LO,
        S_CAPT
    } state_t;

endpackage

// File: rtl/present_bus_master.sv
// present_bus_master: writes key/data to the PRESENT peripheral, waits for the core, reads the result back (optional key cache: PRESENT_KEY_CACHE_EN)
module present_bus_master
    import present_pkg::*;
#(
    parameter int WAIT_CYCLES = 40
) (
    input  logic             clk,
    input  logic             iReset,
    input  logic             iStart,
    output logic             oReady,
    input  logic [KEY_W-1:0] iKey,
    input  logic [BLK_W-1:0] iData,
    input  logic             iMode,
    output logic             oChipselect_n,
    output logic             oWrite_n,
    output logic             oRead_n,
    output logic [3:0]       oAddress,
    output logic [31:0]      oWdata,
    input  logic [31:0]      iRdata,
    output logic [BLK_W-1:0] oResult,
    output logic             oValid
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_key;
    logic [BLK_W-1:0] r_data;
    logic [BLK_W-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             w_key_hit;
    logic             w_cs_n;
    logic             w_wr_n;
    logic             w_rd_n;
    logic [3:0]       w_addr;
    logic [31:0]      w_wdata;

    assign oReady  = (r_state == S_IDLE);
    assign oResult = r_result;

`ifdef PRESENT_KEY_CACHE_EN
    logic             r_key_valid;
    logic [KEY_W-1:0] r_last_key;

    // remember the key most recently loaded into the core so a repeat can skip the key writes
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            r_key_valid <= 1'b0;
            r_last_key  <= '0;
        end else if (r_state == S_WR_K2) begin
            r_key_valid <= 1'b1;
            r_last_key  <= r_key;
        end
    end

    assign w_key_hit = r_key_valid && (r_key == r_last_key);
`else
    assign w_key_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state, and the bus access belonging to that state so it appears in the same cycle
    always_comb begin
        w_next  = r_state;
        w_cs_n  = 1'b1;
        w_wr_n  = 1'b1;
        w_rd_n  = 1'b1;
        w_addr  = oAddress;
        w_wdata = oWdata;
        case (r_state)
            S_IDLE:    w_next = iStart ? S_WR_CTRL : S_IDLE;
            S_WR_CTRL: w_next = w_key_hit ? S_WR_D0 : S_WR_K0;
            S_WR_K0:   w_next = S_WR_K1;
            S_WR_K1:   w_next = S_WR_K2;
            S_WR_K2:   w_next = S_WR_D0;
            S_WR_D0:   w_next = S_WR_D1;
            S_WR_D1:   w_next = S_WR_LOAD;
            S_WR_LOAD: w_next = S_LD_CLR;
            S_LD_CLR:  w_next = S_WAIT;
            S_WAIT:    w_next = (r_cnt == '0) ? S_RD_HI : S_WAIT;
            S_RD_HI:   w_next = S_RD_LO;
            S_RD_LO:   w_next = S_CAPT;
            default:   w_next = S_IDLE;
        endcase
        // WR_CTRL is only entered from IDLE, so the mode comes straight from the accept inputs
        case (w_next)
            S_WR_CTRL: {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_CTRL, 31'b0, iMode};
            S_WR_K0:   {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_KEY0, r_key[79:48]};
            S_WR_K1:   {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_KEY1, r_key[47:16]};
            S_WR_K2:   {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_KEY2, 16'b0, r_key[15:0]};
            S_WR_D0:   {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_DAT0, r_data[63:32]};
            S_WR_D1:   {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_DAT1, r_data[31:0]};
            S_WR_LOAD: {w_cs_n, w_wr_n, w_addr, w_wdata} = {2'b00, ADDR_LOAD, 32'd1};
            S_LD_CLR:  {w_cs_n, w_addr} = {1'b0, ADDR_LOAD};
            S_RD_HI:   {w_cs_n, w_rd_n, w_addr} = {2'b00, ADDR_RES0};
            S_RD_LO:   {w_cs_n, w_rd_n, w_addr} = {2'b00, ADDR_RES1};
            default:   ;
        endcase
    end

    // registered bus outputs; reset releases the bus immediately
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            oChipselect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= '0;
            oWdata        <= '0;
        end else begin
            oChipselect_n <= w_cs_n;
            oWrite_n      <= w_wr_n;
            oRead_n       <= w_rd_n;
            oAddress      <= w_addr;
            oWdata        <= w_wdata;
        end
    end

    // request latch, wait counter and result capture (read data lags the strobe by one cycle)
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            r_key    <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            oValid   <= 1'b0;
        end else begin
            oValid <= (r_state == S_CAPT);
            if (r_state == S_IDLE && iStart) begin
                r_key  <= iKey;
                r_data <= iData;
            end
            if (r_state == S_LD_CLR)  r_cnt <= CNT_W'(WAIT_CYCLES - 1);
            else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
            if (r_state == S_RD_LO)   r_result[63:32] <= iRdata;
            if (r_state == S_CAPT)    r_result[31:0]  <= iRdata;
        end
    end

endmodule

// File: tb/tb_present_bus_master.sv
// tb_present_bus_master: PRESENT slave model plus scoreboard around present_bus_master
module tb_present_bus_master;

    localparam int W = 40;

    logic        clk = 1'b0;
    logic        iReset, iStart, iMode, oReady, oValid;
    logic        oChipselect_n, oWrite_n, oRead_n;
    logic [79:0] iKey;
    logic [63:0] iData, oResult;
    logic [3:0]  oAddress;
    logic [31:0] oWdata, iRdata;

    int n_cmp = 0, n_bad = 0, cyc = 0, v_count = 0;

    typedef struct { logic [3:0] a; logic [31:0] d; logic wr; logic rd; int c; } acc_t;
    acc_t        tr_q[$];
    logic [63:0] exp_q[$];
    int          acc_q[$];

    logic        g;
    logic [63:0] res, e;
    int          lat;

    always #5 clk = ~clk;

    present_bus_master #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .iReset(iReset), .iStart(iStart), .oReady(oReady),
        .iKey(iKey), .iData(iData), .iMode(iMode),
        .oChipselect_n(oChipselect_n), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
        .oAddress(oAddress), .oWdata(oWdata), .iRdata(iRdata),
        .oResult(oResult), .oValid(oValid)
    );

    // PRESENT-80 reference
    function automatic logic [63:0] sbox_layer(input logic [63:0] s, input logic inv);
        logic [63:0] t_f = 64'h21748FE3DA09B65C;
        logic [63:0] t_i = 64'hA970364BD21C8FE5;
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i+:4] = inv ? t_i[4*s[4*i+:4]+:4] : t_f[4*s[4*i+:4]+:4];
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        int p;
        for (int i = 0; i < 64; i++) begin
            p = (i == 63) ? 63 : (16 * i) % 63;
            if (inv) r[i] = s[p];
            else     r[p] = s[i];
        end
        return r;
    endfunction

    function automatic logic [63:0] present(input logic [63:0] blk, input logic [79:0] key, input logic dec);
        logic [79:0] k = key;
        logic [63:0] rk [1:32];
        logic [63:0] s = blk;
        logic [63:0] t_f = 64'h21748FE3DA09B65C;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = t_f[4*k[79:76]+:4];
            k[19:15] = k[19:15] ^ r[4:0];
        end
        if (!dec) begin
            for (int r = 1; r <= 31; r++) s = p_layer(sbox_layer(s ^ rk[r], 1'b0), 1'b0);
            s = s ^ rk[32];
        end else begin
            s = s ^ rk[32];
            for (int r = 31; r >= 1; r--) s = sbox_layer(p_layer(s, 1'b1), 1'b1) ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [79:0] rnd80();
        logic [95:0] t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int key_writes();
        int n = 0;
        foreach (tr_q[i]) if (tr_q[i].wr && tr_q[i].a >= 4'h1 && tr_q[i].a <= 4'h3) n++;
        return n;
    endfunction

    // peripheral model: ctrl bit0=1 selects decrypt; result readable 31 cycles after load, read data registered
    logic [31:0] s_reg [0:15];
    logic [63:0] s_res = '0;
    logic [31:0] s_rdata = '0;
    int          s_busy = 0;
    assign iRdata = s_rdata;

    always @(posedge clk) begin
        if (s_busy > 0) s_busy <= s_busy - 1;
        if (!oChipselect_n && !oWrite_n) begin
            s_reg[oAddress] <= oWdata;
            if (oAddress == 4'h0 && oWdata[0]) begin
                s_res  <= present({s_reg[4], s_reg[5]}, {s_reg[1], s_reg[2], s_reg[3][15:0]}, s_reg[8][0]);
                s_busy <= 31;
            end
        end
        if (!oChipselect_n && !oRead_n)
            s_rdata <= (s_busy != 0) ? 32'hDEADBEEF : (oAddress == 4'h6 ? s_res[63:32] : s_res[31:0]);
    end

    // cycle counter and bus/valid monitor
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!oChipselect_n) tr_q.push_back('{a: oAddress, d: oWdata, wr: !oWrite_n, rd: !oRead_n, c: cyc});
        if (oValid) v_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic start_req(input logic [79:0] k, input logic [63:0] d, input logic m, input logic [63:0] x);
        int t = 0;
        while (!oReady && t < 200) begin step(1); t++; end
        iKey = k; iData = d; iMode = m; iStart = 1'b1;
        exp_q.push_back(x);
        acc_q.push_back(cyc);
        step(1);
        iStart = 1'b0;
    endtask

    task automatic collect(output logic got, output logic [63:0] r, output logic [63:0] x, output int l);
        int t = 0, vc = 0, a = 0;
        got = 1'b0; r = '0; x = 'x; l = -1;
        while (!got && t < 300) begin
            if (oValid) begin got = 1'b1; r = oResult; vc = cyc; end
            step(1);
            t++;
        end
        if (exp_q.size() > 0) x = exp_q.pop_front();
        if (acc_q.size() > 0) a = acc_q.pop_front();
        if (got) l = vc - a;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({oReady, oChipselect_n, oWrite_n, oRead_n, oValid} !== 5'b11110) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 11110", {oReady, oChipselect_n, oWrite_n, oRead_n, oValid});
        end
        n_cmp++;
        if ({oAddress, oWdata, oResult} !== '0) begin
            n_bad++; $display("FAIL reset_data: got addr=%h wdata=%h result=%h want all 0", oAddress, oWdata, oResult);
        end
        iReset = 1'b0;
        step(2);
    endtask

    task automatic test_encrypt_zero();
        start_req(80'h0, 64'h0, 1'b0, 64'h5579C1387B228445);
        n_cmp++;
        if (oReady !== 1'b0) begin n_bad++; $display("FAIL enc0_busy: oReady got %b want 0", oReady); end
        collect(g, res, e, lat);
        n_cmp++; if (g !== 1'b1)  begin n_bad++; $display("FAIL enc0_valid: got %b want 1", g); end
        n_cmp++; if (res !== e)   begin n_bad++; $display("FAIL enc0_result: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL enc0_latency: got %0d want %0d", lat, 12 + W); end
        step(5);
        n_cmp++; if (oResult !== e) begin n_bad++; $display("FAIL enc0_hold: got %h want %h", oResult, e); end
    endtask

    task automatic test_bus_trace();
        logic [3:0]  ea [10] = '{4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h0, 4'h0, 4'h6, 4'h7};
        logic [31:0] ed [7]  = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
        logic [1:0]  kind;
        tr_q.delete();
        start_req({80{1'b1}}, {64{1'b1}}, 1'b0, 64'h3333DCD3213210D2);
        collect(g, res, e, lat);
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL encF_result: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL encF_latency: got %0d want %0d", lat, 12 + W); end
        n_cmp++; if (tr_q.size() !== 10) begin n_bad++; $display("FAIL trace_len: got %0d want 10", tr_q.size()); end
        for (int i = 0; i < 10 && i < tr_q.size(); i++) begin
            kind = (i < 7) ? 2'b10 : (i == 7) ? 2'b00 : 2'b01;
            n_cmp++;
            if ({tr_q[i].a, tr_q[i].wr, tr_q[i].rd} !== {ea[i], kind}) begin
                n_bad++; $display("FAIL trace_acc%0d: got a=%h wr=%b rd=%b want a=%h wr/rd=%b", i, tr_q[i].a, tr_q[i].wr, tr_q[i].rd, ea[i], kind);
            end
            if (i < 7) begin
                n_cmp++;
                if (tr_q[i].d !== ed[i]) begin n_bad++; $display("FAIL trace_wdata%0d: got %h want %h", i, tr_q[i].d, ed[i]); end
            end
            if (i > 0 && i < 8) begin
                n_cmp++;
                if (tr_q[i].c !== tr_q[i-1].c + 1) begin n_bad++; $display("FAIL trace_gap%0d: got cycle %0d want %0d", i, tr_q[i].c, tr_q[i-1].c + 1); end
            end
        end
        if (tr_q.size() >= 9) begin
            n_cmp++;
            if (tr_q[8].c - tr_q[7].c !== W + 1) begin n_bad++; $display("FAIL trace_wait: got %0d want %0d", tr_q[8].c - tr_q[7].c, W + 1); end
        end
    endtask

    task automatic test_decrypt();
        tr_q.delete();
        start_req(80'h0, 64'h5579C1387B228445, 1'b1, 64'h0);
        collect(g, res, e, lat);
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL dec_result: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL dec_latency: got %0d want %0d", lat, 12 + W); end
        n_cmp++;
        if (tr_q.size() < 1 || tr_q[0].d !== 32'h1) begin n_bad++; $display("FAIL dec_ctrl: got %h want 00000001", tr_q.size() ? tr_q[0].d : 32'hx); end
    endtask

    task automatic test_start_ignored();
        logic [79:0] k = rnd80();
        logic [63:0] d = rnd64();
        int v0 = v_count;
        start_req(k, d, 1'b0, present(d, k, 1'b0));
        step(15);
        iKey = ~k; iData = ~d; iStart = 1'b1;
        step(1);
        iStart = 1'b0;
        collect(g, res, e, lat);
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL ign_result: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL ign_latency: got %0d want %0d", lat, 12 + W); end
        step(60);
        n_cmp++; if (v_count - v0 !== 1) begin n_bad++; $display("FAIL ign_count: got %0d valids want 1", v_count - v0); end
    endtask

    task automatic test_back_to_back();
        logic [79:0] ka = rnd80(), kb = rnd80();
        logic [63:0] da = rnd64(), db = rnd64();
        int t = 0;
        while (!oReady && t < 200) begin step(1); t++; end
        iKey = ka; iData = da; iMode = 1'b0; iStart = 1'b1;
        exp_q.push_back(present(da, ka, 1'b0));
        acc_q.push_back(cyc);
        exp_q.push_back(present(db, kb, 1'b0));
        acc_q.push_back(cyc + 12 + W);
        step(1);
        iKey = kb; iData = db;
        collect(g, res, e, lat);
        iStart = 1'b0;
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL b2b_first: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL b2b_first_lat: got %0d want %0d", lat, 12 + W); end
        collect(g, res, e, lat);
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL b2b_second: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL b2b_second_lat: got %0d want %0d", lat, 12 + W); end
    endtask

    task automatic test_reset_mid();
        logic [79:0] k = rnd80();
        logic [63:0] d = rnd64();
        int t = 0, v0;
        start_req(k, d, 1'b0, 64'h0);
        while (!(oChipselect_n === 1'b0 && oAddress === 4'h4) && t < 100) begin step(1); t++; end
        n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL rst_reach_d0: got timeout want WR_D0 access"); end
        #1 iReset = 1'b1;
        #1;
        n_cmp++;
        if ({oChipselect_n, oWrite_n, oRead_n, oReady, oValid} !== 5'b11110) begin
            n_bad++; $display("FAIL rst_mid: got %b want 11110", {oChipselect_n, oWrite_n, oRead_n, oReady, oValid});
        end
        @(posedge clk); #2;
        iReset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        v0 = v_count;
        step(70);
        n_cmp++; if (v_count !== v0) begin n_bad++; $display("FAIL rst_no_valid: got %0d valids want 0", v_count - v0); end
        start_req(k, d, 1'b0, present(d, k, 1'b0));
        collect(g, res, e, lat);
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL rst_after: got %h want %h", res, e); end
        n_cmp++; if (lat !== 12 + W) begin n_bad++; $display("FAIL rst_after_lat: got %0d want %0d", lat, 12 + W); end
    endtask

    task automatic test_key_cache();
        logic [79:0] k = rnd80();
        logic [63:0] d1 = rnd64(), d2 = rnd64(), d3 = rnd64();
`ifdef PRESENT_KEY_CACHE_EN
        int hit_lat = 9 + W, hit_kw = 0;
`else
        int hit_lat = 12 + W, hit_kw = 3;
`endif
        tr_q.delete();
        start_req(k, d1, 1'b0, present(d1, k, 1'b0));
        collect(g, res, e, lat);
        n_cmp++; if (res !== e || lat !== 12 + W) begin n_bad++; $display("FAIL kc_first: got %h/%0d want %h/%0d", res, lat, e, 12 + W); end
        n_cmp++; if (key_writes() !== 3) begin n_bad++; $display("FAIL kc_first_kw: got %0d want 3", key_writes()); end
        tr_q.delete();
        start_req(k, d2, 1'b0, present(d2, k, 1'b0));
        collect(g, res, e, lat);
        n_cmp++; if (res !== e) begin n_bad++; $display("FAIL kc_same_result: got %h want %h", res, e); end
        n_cmp++; if (lat !== hit_lat) begin n_bad++; $display("FAIL kc_same_lat: got %0d want %0d", lat, hit_lat); end
        n_cmp++; if (key_writes() !== hit_kw) begin n_bad++; $display("FAIL kc_same_kw: got %0d want %0d", key_writes(), hit_kw); end
        tr_q.delete();
        start_req(~k, d3, 1'b0, present(d3, ~k, 1'b0));
        collect(g, res, e, lat);
        n_cmp++; if (res !== e || lat !== 12 + W) begin n_bad++; $display("FAIL kc_new: got %h/%0d want %h/%0d", res, lat, e, 12 + W); end
        n_cmp++; if (key_writes() !== 3) begin n_bad++; $display("FAIL kc_new_kw: got %0d want 3", key_writes()); end
    endtask

    initial begin
        iReset = 1'b1; iStart = 1'b0; iMode = 1'b0; iKey = '0; iData = '0;
        @(posedge clk); #2;
        test_reset();
        test_encrypt_zero();
        test_bus_trace();
        test_decrypt();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_key_cache();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
